// File: rtl/aes_redundancy.sv
// AES-128 encryptor built from two independent, iterative datapaths; the
// registered ciphertext is released only when both copies agree.
`timescale 1ns/1ps

// Combinational AES forward S-box, table form.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[data];
endmodule

// One complete AES-128 datapath: state register, round-key register and
// on-the-fly key expansion. Byte i of every 128-bit word lives in bits [8i+7:8i].
module aes_copy (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   round,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] result
);
  localparam logic [3:0] LOAD  = 4'd0;
  localparam logic [3:0] FINAL = 4'd10;

  logic [127:0] state;
  logic [127:0] round_key;
  logic [127:0] sub_state;
  logic [127:0] shifted;
  logic [127:0] next_key;
  logic [127:0] next_state;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [7:0]   rcon;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[32*c + 8*r +: 8] = s[32*((c + r) % 4) + 8*r +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .data (state[8*i +: 8]),
      .sub  (sub_state[8*i +: 8])
    );
  end

  // RotWord of the last key word: bytes {b0,b1,b2,b3} become {b1,b2,b3,b0}.
  assign rot_word = {round_key[103:96], round_key[127:104]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .data (rot_word[8*j +: 8]),
      .sub  (sub_word[8*j +: 8])
    );
  end

  // NOTE: every always_comb output is assigned on every path (here via the
  // default arm) so no latch is inferred.
  always_comb begin
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    logic [31:0] w0, w1, w2, w3;
    w0 = round_key[31:0] ^ sub_word ^ {24'h0, rcon};
    w1 = round_key[63:32] ^ w0;
    w2 = round_key[95:64] ^ w1;
    w3 = round_key[127:96] ^ w2;
    next_key = {w3, w2, w1, w0};
  end

  assign shifted    = shift_rows(sub_state);
  assign next_state = ((round == FINAL) ? shifted : mix_columns(shifted)) ^ next_key;
  assign result     = next_state;

  // NOTE: non-blocking assignments so both copies and the controller all see
  // the same pre-edge values; the datapath registers are reset as well so an
  // aborted block leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      round_key <= '0;
    end else if (round == LOAD) begin
      state     <= plaintext ^ key;
      round_key <= key;
    end else begin
      state     <= next_state;
      round_key <= next_key;
    end
  end
endmodule

// Top level: shared round counter, two datapath copies and the comparing
// output register. rst_n is a synchronous, active-high reset despite its name.
module aes_redundancy #(
  parameter logic [127:0] FAIL_VALUE = 128'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] plaintext_in,
  input  logic [127:0] key_in,
  output logic [127:0] ciphertext_out
);
  localparam logic [3:0] LOAD    = 4'd0;
  localparam logic [3:0] ROUND10 = 4'd10;

  logic [3:0]   round;
  logic [127:0] result_a;
  logic [127:0] result_b;

  aes_copy copy_a (
    .clk       (clk),
    .rst       (rst_n),
    .round     (round),
    .plaintext (plaintext_in),
    .key       (key_in),
    .result    (result_a)
  );

  aes_copy copy_b (
    .clk       (clk),
    .rst       (rst_n),
    .round     (round),
    .plaintext (plaintext_in),
    .key       (key_in),
    .result    (result_b)
  );

  // Unreachable counts above ROUND10 also fall back to LOAD.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      round <= LOAD;
    end else if (round >= ROUND10) begin
      round <= LOAD;
    end else begin
      round <= round + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ciphertext_out <= '0;
    end else if (round == ROUND10) begin
      ciphertext_out <= (result_a == result_b) ? result_a : FAIL_VALUE;
    end
  end
endmodule

// File: tb/tb_aes_redundancy.sv
// Self-checking bench for aes_redundancy: FIPS-197 vectors, random blocks
// against a byte-array AES model, input-change, fault and mid-block reset cases.
`timescale 1ns/1ps

module tb_aes_redundancy;
  localparam logic [127:0] FAIL_VALUE = 128'h0;
  localparam logic [127:0] PT_B  = 128'h340737E0A29831318D305A88A8F64332;
  localparam logic [127:0] KEY_B = 128'h3C4FCF098815F7ABA6D2AE2816157E2B;
  localparam logic [127:0] CT_B  = 128'h320B6A19978511DCFB09DC021D842539;
  localparam logic [127:0] PT_C  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] KEY_C = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] CT_C  = 128'h5AC5B47080B7CDD830047B6AD8E0C469;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] plaintext_in;
  logic [127:0] key_in;
  logic [127:0] ciphertext_out;

  int           n_checks = 0;
  int           n_fails  = 0;
  logic [127:0] last_exp;
  logic [7:0]   sbox_tab [256];

  aes_redundancy dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .plaintext_in   (plaintext_in),
    .key_in         (key_in),
    .ciphertext_out (ciphertext_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the FIPS affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = gmul(b, x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   a [4];
    logic [7:0]   rc, t0;
    logic [127:0] out;
    for (int k = 0; k < 16; k++) w[k] = key[8*k +: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
      if (i % 4 == 0) begin
        t0     = tmp[0];
        tmp[0] = sbox_tab[tmp[1]] ^ rc;
        tmp[1] = sbox_tab[tmp[2]];
        tmp[2] = sbox_tab[tmp[3]];
        tmp[3] = sbox_tab[t0];
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
    end
    for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ w[k];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_tab[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c + r];
          for (int r = 0; r < 4; r++)
            s[4*c + r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[16*rnd + k];
    end
    out = '0;
    for (int k = 0; k < 16; k++) out[8*k +: 8] = s[k];
    return out;
  endfunction

  // ---------------- helpers ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] expected);
    n_checks++;
    assert (ciphertext_out === expected) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, ciphertext_out, expected);
    end
  endtask

  // Called right after an output edge (counter back at LOAD).
  task automatic run_block(input string tag, input logic [127:0] pt,
                           input logic [127:0] key, input logic [127:0] expected);
    plaintext_in = pt;
    key_in       = key;
    wait_edges(10);
    check({tag, "_hold"}, last_exp);
    wait_edges(1);
    check(tag, expected);
    last_exp = expected;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] pt1, pt2, key1, v;

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    rst_n        = 1'b1;
    plaintext_in = '0;
    key_in       = '0;
    wait_edges(3);
    check("reset_value", 128'h0);

    // App. B vector straight out of reset; output stays 0 until the 11th edge.
    plaintext_in = PT_B;
    key_in       = KEY_B;
    rst_n        = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      wait_edges(1);
      check($sformatf("pre_first_out_edge%0d", k), 128'h0);
    end
    wait_edges(1);
    check("fips_app_b", CT_B);
    last_exp = CT_B;

    run_block("fips_app_c1", PT_C, KEY_C, CT_C);
    run_block("all_zero", 128'h0, 128'h0, aes_ref(128'h0, 128'h0));
    run_block("all_ones", '1, '1, aes_ref('1, '1));

    for (int n = 0; n < 6; n++) begin
      pt1  = {$urandom, $urandom, $urandom, $urandom};
      key1 = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("random_%0d", n), pt1, key1, aes_ref(pt1, key1));
    end

    // Plaintext changes during round 4: current block keeps the old input.
    pt1  = {$urandom, $urandom, $urandom, $urandom};
    pt2  = {$urandom, $urandom, $urandom, $urandom};
    key1 = {$urandom, $urandom, $urandom, $urandom};
    plaintext_in = pt1;
    key_in       = key1;
    wait_edges(4);
    plaintext_in = pt2;
    wait_edges(6);
    check("input_change_hold", last_exp);
    wait_edges(1);
    check("input_change_old", aes_ref(pt1, key1));
    last_exp = aes_ref(pt1, key1);
    run_block("input_change_new", pt2, key1, aes_ref(pt2, key1));

    // Flip one bit of copy B's state during round 5.
    plaintext_in = PT_B;
    key_in       = KEY_B;
    wait_edges(5);
    v = dut.copy_b.state;
    force dut.copy_b.state = v ^ 128'h1;
    wait_edges(1);
    release dut.copy_b.state;
    wait_edges(5);
    check("fault_block", FAIL_VALUE);
    last_exp = FAIL_VALUE;
    run_block("fault_recover", PT_B, KEY_B, CT_B);

    // Reset for one cycle during round 6 aborts the block.
    plaintext_in = PT_C;
    key_in       = KEY_C;
    wait_edges(6);
    rst_n = 1'b1;
    wait_edges(1);
    check("abort_clear", 128'h0);
    rst_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      wait_edges(1);
      check($sformatf("abort_no_output_edge%0d", k), 128'h0);
    end
    wait_edges(1);
    check("abort_restart", CT_C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
